// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one combinational ALU. A round-robin
// grant picks one transaction at a time, the operands are registered and
// driven to the ALU for one cycle, and the result is held for the owner
// until it is accepted.
// Optional feature macro: ALU_ARB_ILLEGAL_OP_EN. When defined, opcodes
// 4'b1010..4'b1111 are replaced by a harmless ADD of zeros and flagged on
// resp_err with a zero result.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [3:0]       req_op0,
    input  logic [3:0]       req_op1,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_err
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic             ptr_reg;
    logic             owner_reg;
    logic [3:0]       op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] result_reg;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic             err_reg;
    logic             sel_illegal;
`endif

    logic             grant_id;
    logic             accept;
    logic             resp_active;
    logic [3:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // Round-robin grant: a lone valid requester wins, a tie goes to the pointer.
    always_comb begin
        grant_id = 1'b0;
        if (req_valid == 2'b11) begin
            grant_id = ptr_reg;
        end else begin
            grant_id = req_valid[1];
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_op = grant_id ? req_op1 : req_op0;
        sel_a  = grant_id ? req_a1  : req_a0;
        sel_b  = grant_id ? req_b1  : req_b0;
    end

`ifdef ALU_ARB_ILLEGAL_OP_EN
    assign sel_illegal = (sel_op >= 4'b1010);
`endif

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state and handshake strobes; reset masks both handshakes.
    always_comb begin
        state_next  = state_reg;
        accept      = 1'b0;
        resp_active = 1'b0;
        case (state_reg)
            IDLE: begin
                accept = !RST && req_valid[grant_id];
                if (accept) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                resp_active = !RST;
                if (resp_ready[owner_reg]) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Per-requester handshake bits.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign req_ready[gi]  = accept && (grant_id == 1'(gi));
        assign resp_valid[gi] = resp_active && (owner_reg == 1'(gi));
    end

    // Datapath: capture the request on accept, capture the ALU result in EXEC.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_reg    <= 1'b0;
            owner_reg  <= 1'b0;
            op_reg     <= 4'b0000;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
            err_reg    <= 1'b0;
`endif
        end else begin
            if (accept) begin
                owner_reg <= grant_id;
                ptr_reg   <= ~grant_id;
`ifdef ALU_ARB_ILLEGAL_OP_EN
                err_reg   <= sel_illegal;
                if (sel_illegal) begin
                    op_reg <= 4'b0011;
                    a_reg  <= '0;
                    b_reg  <= '0;
                end else begin
                    op_reg <= sel_op;
                    a_reg  <= sel_a;
                    b_reg  <= sel_b;
                end
`else
                op_reg    <= sel_op;
                a_reg     <= sel_a;
                b_reg     <= sel_b;
`endif
            end
            if (state_reg == EXEC) begin
`ifdef ALU_ARB_ILLEGAL_OP_EN
                result_reg <= err_reg ? '0 : alu_result;
`else
                result_reg <= alu_result;
`endif
            end
        end
    end

    assign alu_op      = op_reg;
    assign alu_a       = a_reg;
    assign alu_b       = b_reg;
    assign resp_result = result_reg;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    assign resp_err    = err_reg;
`else
    assign resp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios followed by randomized
// transactions, all compared against a transaction-level reference model
// (grant history queue plus an arithmetic ALU function).
module tb_alu_arbiter;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [3:0]   req_op0;
    logic [3:0]   req_op1;
    logic [W-1:0] req_a0;
    logic [W-1:0] req_b0;
    logic [W-1:0] req_a1;
    logic [W-1:0] req_b1;
    logic [3:0]   alu_op;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_result;
    logic [1:0]   resp_valid;
    logic [1:0]   resp_ready;
    logic [W-1:0] resp_result;
    logic         resp_err;

    int checks   = 0;
    int failures = 0;
    int hist[$];   // winners of past accepts since the last reset

    always #5 CLK = ~CLK;

    // External ALU model (any function of op/a/b works for the arbiter).
    function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a ^ b;
            4'd3:    return a + b;
            4'd4:    return a - b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return $signed(a) >>> b[4:0];
            4'd8:    return W'($signed(a) < $signed(b));
            4'd9:    return W'(a < b);
            default: return a ^ ~b;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_op, alu_a, alu_b);

    alu_arbiter #(.WIDTH(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op0    (req_op0),
        .req_op1    (req_op1),
        .req_a0     (req_a0),
        .req_b0     (req_b0),
        .req_a1     (req_a1),
        .req_b1     (req_b1),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_result(resp_result),
        .resp_err   (resp_err)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".req_ready"},   W'(req_ready),   '0);
        chk({tag, ".resp_valid"},  W'(resp_valid),  '0);
        chk({tag, ".resp_result"}, resp_result,     '0);
        chk({tag, ".resp_err"},    W'(resp_err),    '0);
        chk({tag, ".alu_op"},      W'(alu_op),      '0);
        chk({tag, ".alu_a"},       alu_a,           '0);
        chk({tag, ".alu_b"},       alu_b,           '0);
    endtask

    // One complete transaction: arbitration, EXEC, RESP with optional stall,
    // during which the non-owner resp_ready bit is held high.
    task automatic run_txn(input string tag, input logic [1:0] v,
                           input logic [3:0] o0, input logic [W-1:0] x0, input logic [W-1:0] y0,
                           input logic [3:0] o1, input logic [W-1:0] x1, input logic [W-1:0] y1,
                           input int stall);
        int           w;
        logic [1:0]   wbit;
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   eop;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic [W-1:0] er;
        logic         ee;
        next_cycle();
        req_valid  = v;
        req_op0 = o0; req_a0 = x0; req_b0 = y0;
        req_op1 = o1; req_a1 = x1; req_b1 = y1;
        resp_ready = 2'b00;
        if (v == 2'b11) w = (hist.size() == 0) ? 0 : 1 - hist[$];
        else            w = v[1] ? 1 : 0;
        wbit = 2'b01 << w;
        op = (w == 1) ? o1 : o0;
        a  = (w == 1) ? x1 : x0;
        b  = (w == 1) ? y1 : y0;
        eop = op; ea = a; eb = b; ee = 1'b0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
        if (op >= 4'd10) begin
            eop = 4'd3; ea = '0; eb = '0; ee = 1'b1;
        end
        er = ee ? '0 : alu_fn(eop, ea, eb);
`else
        er = alu_fn(op, a, b);
`endif
        #2;
        chk({tag, ".grant"}, W'(req_ready), W'(wbit));
        $display("txn %s: valid=%b winner=%0d op=%h a=%h b=%h expect result=%h err=%0d",
                 tag, v, w, op, a, b, er, ee);
        // EXEC: loser keeps requesting and must not be accepted.
        next_cycle();
        hist.push_back(w);
        req_valid = v & ~wbit;
        #2;
        chk({tag, ".exec_op"},    W'(alu_op),     W'(eop));
        chk({tag, ".exec_a"},     alu_a,          ea);
        chk({tag, ".exec_b"},     alu_b,          eb);
        chk({tag, ".exec_rv"},    W'(resp_valid), '0);
        chk({tag, ".exec_ready"}, W'(req_ready),  '0);
        // RESP: hold until the owner accepts.
        next_cycle();
        for (int s = 0; s < stall; s++) begin
            resp_ready = ~wbit;
            #2;
            chk({tag, ".stall_rv"},    W'(resp_valid), W'(wbit));
            chk({tag, ".stall_res"},   resp_result,    er);
            chk({tag, ".stall_err"},   W'(resp_err),   W'(ee));
            chk({tag, ".stall_ready"}, W'(req_ready),  '0);
            chk({tag, ".stall_op"},    W'(alu_op),     W'(eop));
            next_cycle();
        end
        resp_ready = wbit;
        #2;
        chk({tag, ".resp_rv"},  W'(resp_valid), W'(wbit));
        chk({tag, ".resp_res"}, resp_result,    er);
        chk({tag, ".resp_err"}, W'(resp_err),   W'(ee));
        next_cycle();
        resp_ready = 2'b00;
        req_valid  = 2'b00;
        #2;
        chk({tag, ".done_rv"}, W'(resp_valid), '0);
    endtask

    initial begin
        RST = 1'b1;
        req_valid = 2'b11;
        resp_ready = 2'b00;
        req_op0 = '0; req_op1 = '0;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        repeat (2) next_cycle();
        #2;
        chk_reset_outputs("reset");
        hist.delete();
        next_cycle();
        RST = 1'b0;
        req_valid = 2'b00;

        // Contention out of reset: grant order 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            run_txn($sformatf("contend%0d", i), 2'b11,
                    4'd3, W'(100 + i), W'(i), 4'd4, W'(200 + i), W'(7), 0);
        end

        // Single ADD 5 + 7 -> 12.
        run_txn("add", 2'b01, 4'd3, 32'd5, 32'd7, 4'd0, '0, '0, 0);
        chk("add.value", resp_result, 32'd12);

        // SUB 3 - 5 from requester 1 with 5 stall cycles (non-owner ready high).
        run_txn("sub_bp", 2'b10, 4'd0, '0, '0, 4'd4, 32'd3, 32'd5, 5);
        chk("sub_bp.value", resp_result, 32'hFFFF_FFFE);

        // Illegal opcode 4'b1100.
        run_txn("illegal", 2'b01, 4'b1100, 32'h1234_5678, 32'h0F0F_0F0F, 4'd0, '0, '0, 1);

        // Reset pulsed during EXEC aborts the transaction.
        next_cycle();
        req_valid = 2'b01; req_op0 = 4'd3; req_a0 = 32'd1; req_b0 = 32'd2;
        #2;
        chk("abort.grant", W'(req_ready), W'(2'b01));
        next_cycle();
        req_valid = 2'b00;
        RST = 1'b1;
        next_cycle();
        #2;
        chk_reset_outputs("abort");
        hist.delete();
        RST = 1'b0;
        resp_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            #2;
            chk($sformatf("abort.no_resp%0d", i), W'(resp_valid), '0);
        end
        resp_ready = 2'b00;

        // Randomized transactions.
        for (int i = 0; i < 30; i++) begin
            run_txn($sformatf("rand%0d", i), 2'($urandom_range(1, 3)),
                    4'($urandom_range(0, 15)), $urandom, $urandom,
                    4'($urandom_range(0, 15)), $urandom, $urandom,
                    int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
